// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: core writeback has priority, long-latency unit results
// wait in a small FIFO and drain on idle port cycles, with a one-cycle forced drain against starvation.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    output logic                     wb_stall,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [4:0]               lu_rd,
    input  logic [XLEN-1:0]          lu_data,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    input  logic [4:0]               q_rd,
    output logic                     q_hit,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    typedef enum logic {NORMAL, FORCE} state_t;

    entry_t        fifo [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic [SW-1:0] starve, starve_nxt;
    state_t        state, state_nxt;
    logic          push, pop, live;

    assign fifo_count = count;
    assign lu_ready   = !rst && (count != (AW+1)'(DEPTH));
    assign wb_stall   = !rst && (state == FORCE);
    assign push       = lu_valid && lu_ready && (lu_rd != 5'd0);
    assign live       = wb_valid && (wb_rd != 5'd0) && !wb_stall;
    // In FORCE live is low, so the head always wins that cycle.
    assign pop        = (count != '0) && !live;

    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((AW+1)'(i) < count) && (fifo[head + AW'(i)].rd == q_rd))
                q_hit = 1'b1;
        end
        if (q_rd == 5'd0)
            q_hit = 1'b0;
    end

    always_comb begin
        starve_nxt = starve;
        state_nxt  = state;
        if ((count == '0) || pop)
            starve_nxt = '0;
        else if (starve != SW'(STARVE_LIMIT))
            starve_nxt = starve + SW'(1);
        case (state)
            NORMAL: if (starve_nxt == SW'(STARVE_LIMIT)) state_nxt = FORCE;
            FORCE:  state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo[tail] <= '{rd: lu_rd, data: lu_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            starve   <= '0;
            state    <= NORMAL;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state  <= state_nxt;
            starve <= starve_nxt;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push)
                tail <= tail + AW'(1);
            if (pop)
                head <= head + AW'(1);
            rf_we <= live || pop;
            if (live) begin
                rf_waddr <= wb_rd;
                rf_wdata <= wb_data;
            end else if (pop) begin
                rf_waddr <= fifo[head].rd;
                rf_wdata <= fifo[head].data;
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scenarios plus a randomized run checked against a queue-based model of the arbiter.
module tb_wb_port_arbiter;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic            clk, rst;
    logic            wb_valid, wb_stall, lu_valid, lu_ready, rf_we, q_hit;
    logic [4:0]      wb_rd, lu_rd, rf_waddr, q_rd;
    logic [XLEN-1:0] wb_data, lu_data, rf_wdata;
    logic [2:0]      fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .q_rd(q_rd), .q_hit(q_hit), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0; q_rd = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick(); tick();
        n_cmp++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            n_err++; $display("FAIL reset_rf: got we=%0b addr=%0d data=%0h expected 0/0/0", rf_we, rf_waddr, rf_wdata); end
        n_cmp++; if (fifo_count !== 3'd0 || lu_ready !== 1'b0 || wb_stall !== 1'b0) begin
            n_err++; $display("FAIL reset_ctl: got cnt=%0d ready=%0b stall=%0b expected 0/0/0", fifo_count, lu_ready, wb_stall); end
        rst = 0; #1;
        n_cmp++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_out: got %0b expected 1", lu_ready); end
        wb_valid = 1; wb_rd = 5'd2; wb_data = 32'h2222;
        lu_valid = 1;
        for (int i = 0; i < 3; i++) begin
            lu_rd = 5'(10 + i); lu_data = 32'(i);
            tick();
        end
        n_cmp++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL reset_fill: got %0d expected 3", fifo_count); end
        lu_valid = 0; wb_valid = 0;
        tick();
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10) begin
            n_err++; $display("FAIL reset_drain: got we=%0b addr=%0d expected 1/10", rf_we, rf_waddr); end
        rst = 1; #1;
        n_cmp++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_in: got %0b expected 0", lu_ready); end
        tick();
        n_cmp++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin
            n_err++; $display("FAIL reset_mid: got we=%0b cnt=%0d expected 0/0", rf_we, fifo_count); end
        tick();
        rst = 0; #1;
        n_cmp++; if (lu_ready !== 1'b1 || fifo_count !== 3'd0) begin
            n_err++; $display("FAIL reset_after: got ready=%0b cnt=%0d expected 1/0", lu_ready, fifo_count); end
        tick();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_nowrite: got %0b expected 0", rf_we); end
    endtask

    task automatic test_core_only();
        idle();
        wb_valid = 1; wb_rd = 5'd5; wb_data = 32'h12345678;
        tick();
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h12345678) begin
            n_err++; $display("FAIL core_write: got we=%0b addr=%0d data=%0h expected 1/5/12345678", rf_we, rf_waddr, rf_wdata); end
        idle();
        tick();
        n_cmp++; if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h12345678) begin
            n_err++; $display("FAIL core_hold: got we=%0b addr=%0d data=%0h expected 0/5/12345678", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_lu_idle();
        idle();
        lu_valid = 1; lu_rd = 5'd7; lu_data = 32'hDEADBEEF;
        tick();
        idle();
        n_cmp++; if (fifo_count !== 3'd1 || rf_we !== 1'b0) begin
            n_err++; $display("FAIL lu_push: got cnt=%0d we=%0b expected 1/0", fifo_count, rf_we); end
        tick();
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEADBEEF || fifo_count !== 3'd0) begin
            n_err++; $display("FAIL lu_drain: got we=%0b addr=%0d data=%0h cnt=%0d expected 1/7/deadbeef/0",
                              rf_we, rf_waddr, rf_wdata, fifo_count); end
    endtask

    task automatic test_starve();
        int k = 0;
        idle();
        wb_valid = 1; wb_rd = 5'd3;
        for (int cyc = 0; cyc < 12; cyc++) begin
            wb_data  = 32'h300 + 32'(k);
            lu_valid = (cyc == 0); lu_rd = 5'd9; lu_data = 32'h99;
            #1;
            n_cmp++; if (wb_stall !== (cyc == 9)) begin
                n_err++; $display("FAIL starve_stall c%0d: got %0b expected %0b", cyc, wb_stall, cyc == 9); end
            tick();
            if (cyc == 9) begin
                n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99) begin
                    n_err++; $display("FAIL starve_force: got we=%0b addr=%0d data=%0h expected 1/9/99", rf_we, rf_waddr, rf_wdata); end
            end else begin
                n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h300 + 32'(k)) begin
                    n_err++; $display("FAIL starve_core c%0d: got we=%0b addr=%0d data=%0h expected 1/3/%0h",
                                      cyc, rf_we, rf_waddr, rf_wdata, 32'h300 + 32'(k)); end
                k++;
            end
        end
        idle();
        n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL starve_empty: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_full_hazard();
        idle();
        wb_valid = 1; wb_rd = 5'd6; wb_data = 32'h66;
        lu_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            lu_rd = 5'(i); lu_data = 32'hA0 + 32'(i);
            tick();
        end
        lu_rd = 5'd5; lu_data = 32'hA5;
        q_rd = 5'd3; #1;
        n_cmp++; if (fifo_count !== 3'd4 || lu_ready !== 1'b0) begin
            n_err++; $display("FAIL full: got cnt=%0d ready=%0b expected 4/0", fifo_count, lu_ready); end
        n_cmp++; if (q_hit !== 1'b1) begin n_err++; $display("FAIL hit_rd3: got %0b expected 1", q_hit); end
        q_rd = 5'd0; #1;
        n_cmp++; if (q_hit !== 1'b0) begin n_err++; $display("FAIL hit_rd0: got %0b expected 0", q_hit); end
        q_rd = 5'd5; #1;
        n_cmp++; if (q_hit !== 1'b0) begin n_err++; $display("FAIL hit_rd5: got %0b expected 0", q_hit); end
        tick();
        lu_valid = 0; wb_valid = 0; q_rd = 5'd1; #1;
        n_cmp++; if (q_hit !== 1'b1) begin n_err++; $display("FAIL hit_head: got %0b expected 1", q_hit); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'(i) || rf_wdata !== 32'hA0 + 32'(i)) begin
                n_err++; $display("FAIL drain_order %0d: got we=%0b addr=%0d data=%0h", i, rf_we, rf_waddr, rf_wdata); end
        end
        idle();
    endtask

    task automatic test_x0();
        idle();
        lu_valid = 1; lu_rd = 5'd0; lu_data = 32'hBAD;
        tick();
        idle();
        n_cmp++; if (fifo_count !== 3'd0 || rf_we !== 1'b0) begin
            n_err++; $display("FAIL x0_lu: got cnt=%0d we=%0b expected 0/0", fifo_count, rf_we); end
        wb_valid = 1; wb_rd = 5'd4; wb_data = 32'h44;
        lu_valid = 1; lu_rd = 5'd12; lu_data = 32'hC0C0;
        tick();
        lu_valid = 0; wb_rd = 5'd0;
        tick();
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hC0C0 || fifo_count !== 3'd0) begin
            n_err++; $display("FAIL x0_wb_drain: got we=%0b addr=%0d data=%0h cnt=%0d expected 1/12/c0c0/0",
                              rf_we, rf_waddr, rf_wdata, fifo_count); end
        tick();
        n_cmp++; if (rf_we !== 1'b0 || rf_waddr !== 5'd12) begin
            n_err++; $display("FAIL x0_wb_none: got we=%0b addr=%0d expected 0/12", rf_we, rf_waddr); end
        idle();
    endtask

    task automatic test_random();
        ent_t        mq[$];
        ent_t        e;
        int          blocked = 0;
        bit          frc = 0, g, had, popped, hit, rdy;
        logic [4:0]  ew = 0;
        logic [31:0] ed = 0;
        idle();
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 1500; c++) begin
            wb_valid = ((c % 300) < 150) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 5);
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            lu_valid = ($urandom_range(0, 2) == 0);
            lu_rd    = 5'($urandom_range(0, 7));
            lu_data  = $urandom;
            q_rd     = 5'($urandom_range(0, 7));
            #1;
            hit = 0;
            foreach (mq[i]) if (q_rd != 0 && mq[i].rd == q_rd) hit = 1;
            rdy = (mq.size() < DEPTH);
            n_cmp++; if (wb_stall !== frc || lu_ready !== rdy) begin
                n_err++; $display("FAIL rnd_ctl c%0d: got stall=%0b ready=%0b expected %0b/%0b", c, wb_stall, lu_ready, frc, rdy); end
            n_cmp++; if (q_hit !== hit || fifo_count !== 3'(mq.size())) begin
                n_err++; $display("FAIL rnd_q c%0d: got hit=%0b cnt=%0d expected %0b/%0d", c, q_hit, fifo_count, hit, mq.size()); end
            g = 0; popped = 0;
            had = (mq.size() != 0);
            if (!frc && wb_valid && wb_rd != 0) begin
                g = 1; ew = wb_rd; ed = wb_data;
            end else if (had) begin
                e = mq.pop_front();
                g = 1; popped = 1; ew = e.rd; ed = e.data;
            end
            if (lu_valid && rdy && lu_rd != 0) mq.push_back('{lu_rd, lu_data});
            if (had && !popped) blocked = (blocked < LIMIT) ? blocked + 1 : LIMIT;
            else blocked = 0;
            frc = !frc && (blocked == LIMIT);
            tick();
            n_cmp++; if (rf_we !== g || rf_waddr !== ew || rf_wdata !== ed) begin
                n_err++; $display("FAIL rnd_rf c%0d: got we=%0b addr=%0d data=%0h expected %0b/%0d/%0h",
                                  c, rf_we, rf_waddr, rf_wdata, g, ew, ed); end
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_core_only();
        test_lu_idle();
        test_starve();
        test_full_hazard();
        test_x0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
